fft_bitrev_reader: RTL

Output reorder stage of the FFT datapath. It captures one frame of 2^LOG2N complex results, which the butterfly stages write in bit-reversed order. It then streams the frame out in natural frequency order over a valid/ready interface. It sits after the last butterfly stage and is the read side of the result buffer that the stage sequencer fills.

---
 rtl/fft_bitrev_reader.sv | 113 +++++++++++
 1 files changed

// File: rtl/fft_bitrev_reader.sv
// Result-buffer read side of the FFT: captures one bit-reversed frame, then
// streams it out in natural frequency order over a valid/ready handshake.
module fft_bitrev_reader #(
    parameter int LOG2N = 3,
    parameter int DW    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_re,
    input  logic [DW-1:0]    in_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_re,
    output logic [DW-1:0]    out_im,
    output logic [LOG2N-1:0] out_idx,
    output logic             out_last,
    output logic             frame_done
);

    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LAST_IDX = '1;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [LOG2N-1:0]    r_wr_cnt;
    logic [LOG2N-1:0]    w_wr_cnt_next;
    logic [LOG2N-1:0]    r_rd_cnt;
    logic [LOG2N-1:0]    w_rd_cnt_next;
    logic                r_frame_done;
    logic                w_wr_en;
    logic                w_last_xfer;
    logic [LOG2N-1:0]    w_rd_addr;
    logic [2*DW-1:0]     w_rd_word;
    logic [2*DW-1:0]     r_mem [N];

    // Read address is the read counter with its bits mirrored.
    generate
        for (genvar gi = 0; gi < LOG2N; gi++) begin : g_bitrev
            assign w_rd_addr[gi] = r_rd_cnt[LOG2N-1-gi];
        end
    endgenerate

    always_comb begin
        w_state_next  = r_state;
        w_wr_cnt_next = r_wr_cnt;
        w_rd_cnt_next = r_rd_cnt;
        w_wr_en       = 1'b0;
        w_last_xfer   = 1'b0;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        case (r_state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_wr_en       = 1'b1;
                    w_wr_cnt_next = r_wr_cnt + 1'b1;
                    if (r_wr_cnt == LAST_IDX) begin
                        w_state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_rd_cnt_next = r_rd_cnt + 1'b1;
                    if (r_rd_cnt == LAST_IDX) begin
                        w_state_next = FILL;
                        w_last_xfer  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= FILL;
            r_wr_cnt     <= '0;
            r_rd_cnt     <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_wr_cnt     <= w_wr_cnt_next;
            r_rd_cnt     <= w_rd_cnt_next;
            r_frame_done <= w_last_xfer;
        end
    end

    // Sample storage has no reset; contents are only meaningful once written.
    always_ff @(posedge clk) begin
        if (reset && w_wr_en) begin
            r_mem[r_wr_cnt] <= {in_re, in_im};
        end
    end

    assign w_rd_word  = r_mem[w_rd_addr];
    assign out_re     = w_rd_word[2*DW-1:DW];
    assign out_im     = w_rd_word[DW-1:0];
    assign out_idx    = r_rd_cnt;
    assign out_last   = (r_state == DRAIN) && (r_rd_cnt == LAST_IDX);
    assign frame_done = r_frame_done;

endmodule
